// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the multi-slave AHB-Lite to APB4 bridge: transfer types,
// response codes, controller states and lane-width helper.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    localparam logic RespOkay  = 1'b0;
    localparam logic RespError = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } bridge_state_e;

    // log2 of the number of bytes carried by one data beat
    function automatic int unsigned log2_bytes(int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ahb_apb_strb_gen.sv
// Byte-lane strobe generator: sets lanes addr_lo .. addr_lo + 2**hsize - 1 on
// writes, clipped to the bus width; all zero on reads.
module ahb_apb_strb_gen #(
    parameter int unsigned STRB_W = 4,
    parameter int unsigned LANE_W = 2
) (
    input  logic [2:0]        hsize,
    input  logic [LANE_W-1:0] addr_lo,
    input  logic              write,
    output logic [STRB_W-1:0] strb
);

    always_comb begin
        strb = '0;
        if (write) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (i >= 32'(addr_lo) && i < 32'(addr_lo) + (32'd1 << hsize)) begin
                    strb[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite slave to APB4 master bridge with one-hot decode of NUM_SLAVES
// peripherals, PCLKEN-paced APB phases and two-cycle AHB ERROR responses.
module ahb_apb_bridge_mc
    import ahb_apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_SLAVES   = 5,
    parameter int unsigned SLV_IDX_W    = 3,
    parameter int unsigned SLV_ADDR_LSB = 12
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [3:0]              HPROT,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic                    HREADYIN,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    input  logic                    PCLKEN,
    output logic [NUM_SLAVES-1:0]   PSEL,
    output logic                    PENABLE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned LANE_W = log2_bytes(DATA_WIDTH);

    bridge_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [SLV_IDX_W-1:0]  idx_q, idx_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    logic                  accept;
    logic                  accept_err;
    logic [SLV_IDX_W-1:0]  addr_idx;
    logic [STRB_W-1:0]     strb_calc;
    logic                  unused_bits;

    assign unused_bits = ^{HTRANS[0], HPROT[3:2]};

    assign addr_idx   = HADDR[SLV_ADDR_LSB +: SLV_IDX_W];
    assign accept     = HSEL & HREADYIN & HTRANS[1] & HREADYOUT;
    assign accept_err = (32'(addr_idx) >= NUM_SLAVES) || (32'(HSIZE) > LANE_W);

    ahb_apb_strb_gen #(
        .STRB_W (STRB_W),
        .LANE_W (LANE_W)
    ) u_strb_gen (
        .hsize   (hsize_q),
        .addr_lo (paddr_q[LANE_W-1:0]),
        .write   (pwrite_q),
        .strb    (strb_calc)
    );

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        hsize_d   = hsize_q;
        idx_d     = idx_q;
        pprot_d   = pprot_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        hrdata_d  = hrdata_q;
        HREADYOUT = 1'b1;
        HRESP     = RespOkay;

        case (state_q)
            StIdle, StErr2: begin
                if (state_q == StErr2) begin
                    HRESP = RespError;
                end
                state_d = StIdle;
                if (accept) begin
                    if (accept_err) begin
                        state_d = StErr1;
                    end else begin
                        state_d  = StLatch;
                        paddr_d  = HADDR;
                        pwrite_d = HWRITE;
                        hsize_d  = HSIZE;
                        idx_d    = addr_idx;
                        pprot_d  = {~HPROT[0], 1'b0, HPROT[1]};
                    end
                end
            end
            StLatch: begin
                HREADYOUT = 1'b0;
                if (pwrite_q) begin
                    pwdata_d = HWDATA;
                end
                pstrb_d = strb_calc;
                // PSEL rises here so the APB setup phase spans the next PCLKEN edge
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    psel_d[i] = (32'(idx_q) == 32'(i));
                end
                penable_d = 1'b0;
                state_d   = StSetup;
            end
            StSetup: begin
                HREADYOUT = 1'b0;
                if (PCLKEN) begin
                    penable_d = 1'b1;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                HREADYOUT = 1'b0;
                if (PCLKEN && PREADY) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (PSLVERR) begin
                        state_d = StErr1;
                    end else begin
                        state_d = StIdle;
                        if (!pwrite_q) begin
                            hrdata_d = PRDATA;
                        end
                    end
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = RespError;
                state_d   = StErr2;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= StIdle;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            hsize_q   <= '0;
            idx_q     <= '0;
            pprot_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            hrdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            hsize_q   <= hsize_d;
            idx_q     <= idx_d;
            pprot_q   <= pprot_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            hrdata_q  <= hrdata_d;
        end
    end

    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PSTRB   = pstrb_q;
    assign PPROT   = pprot_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign HRDATA  = hrdata_q;

endmodule
